// File: rtl/hqm_aw_registerram_ctl.sv
// hqm_aw_registerram_ctl: init walk, then shares one register-RAM write port between cfg access and round-robin functional writers
module hqm_aw_registerram_ctl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 2,
  parameter logic [WIDTH-1:0] DEFAULT = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst_prep,
  input  logic [NUM_REQ-1:0]       req_v,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_gnt,
  input  logic                     cfg_write,
  input  logic                     cfg_read,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [31:0]              cfg_wdata,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  output logic [31:0]              cfg_rdata,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_waddr,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic [AW-1:0]            mem_raddr,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic                     init_done
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  if (WIDTH > 32) begin : INVALID_PARAM_COMBINATION
    $error("hqm_aw_registerram_ctl: WIDTH must not exceed 32");
  end
  typedef enum logic [1:0] {INIT, RUN, ACK} state_t;
  state_t          state;
  logic [AW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic            any;
  logic            in_init;
  logic            acc;
  logic            acc_wr;
  logic            acc_rd;
  logic            cfg_ok;
  logic            gnt_en;
  logic [AW-1:0]   g_addr;
  logic [WIDTH-1:0] g_data;
  logic            g_ok;
  logic            unused_wdata;
  assign unused_wdata = ^cfg_wdata;
  // Reset is folded in so the walk's write strobe stays low while rst_n is held.
  assign in_init = (state == INIT) & rst_n;
  assign acc     = (state == RUN) & ~rst_prep & (cfg_write | cfg_read);
  assign acc_wr  = acc & cfg_write;
  assign acc_rd  = acc & ~cfg_write;
  assign cfg_ok  = int'(cfg_addr) < DEPTH;
  // Search starts at the pointer; descending loop leaves the nearest requester in sel.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_v[(int'(ptr) + k) % NUM_REQ]) begin
        sel = PW'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
  assign gnt_en    = (state != INIT) & ~rst_prep & ~acc & any;
  assign g_addr    = req_addr[int'(sel)*AW +: AW];
  assign g_data    = req_wdata[int'(sel)*WIDTH +: WIDTH];
  assign g_ok      = int'(g_addr) < DEPTH;
  assign req_gnt   = gnt_en ? NUM_REQ'(1) << sel : '0;
  assign mem_we    = in_init | (acc_wr & cfg_ok) | (gnt_en & g_ok);
  assign mem_waddr = in_init ? cnt : acc ? cfg_addr : gnt_en ? g_addr : '0;
  assign mem_wdata = in_init ? DEFAULT : acc ? cfg_wdata[WIDTH-1:0] : gnt_en ? g_data : '0;
  assign mem_raddr = acc_rd ? cfg_addr : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      init_done <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      state     <= state == INIT ? (cnt == AW'(DEPTH - 1) ? RUN : INIT) : acc ? ACK : RUN;
      cnt       <= state == INIT ? cnt + 1'b1 : cnt;
      init_done <= init_done | (state == INIT && cnt == AW'(DEPTH - 1));
      ptr       <= gnt_en ? PW'((int'(sel) + 1) % NUM_REQ) : ptr;
      cfg_ack   <= acc;
      cfg_err   <= acc & ~cfg_ok;
      cfg_rdata <= (acc_rd & cfg_ok) ? 32'(mem_rdata) : '0;
    end
  end
endmodule
